// File: rtl/param_define.sv
// Shared loader/PE constants: instruction width, config-buffer depth,
// counter width and the loader state encoding.
`ifndef PE_inst
`define PE_inst 48
`endif

package param_define;

  // PE config-buffer depth; instruction and run counts are clamped to it.
  localparam int PE_DEPTH = 32;

  // Width of the instruction-count and run-length fields.
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } ldr_state_t;

endpackage

// File: rtl/cfg_fetch_pipe.sv
// Two-stage read-return pipe: stage 1 tracks the one-cycle memory latency,
// stage 2 registers the returned word as PE_inst with its init strobe.
module cfg_fetch_pipe #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_rd_en,
  input  logic [W-1:0] i_rdata,
  output logic [W-1:0] o_pe_inst,
  output logic         o_init
);

  logic         r_vld;
  logic         r_init;
  logic [W-1:0] r_inst;

  // Valid follows the read strobe; a flush drops anything in flight so no
  // init escapes after the operation is killed. The word itself is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_init <= 1'b0;
      r_inst <= '0;
    end else begin
      if (i_flush) begin
        r_vld  <= 1'b0;
        r_init <= 1'b0;
      end else begin
        r_vld  <= i_rd_en;
        r_init <= r_vld;
        if (r_vld) begin
          r_inst <= i_rdata;
        end
      end
    end
  end

  assign o_pe_inst = r_inst;
  assign o_init    = r_init;

endmodule

// File: rtl/pe_config_loader.sv
// PE configuration loader: clears the PE, streams inst_num words from config
// memory into the PE config buffer, strobes run for run_cycles, then pulses done.
module pe_config_loader
  import param_define::*;
#(
  parameter int PE_INST_W = `PE_inst,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = PE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [5:0]           inst_num,
  input  logic [5:0]           run_cycles,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PE_INST_W-1:0] mem_rdata,
  output logic                 pe_rst,
  output logic [PE_INST_W-1:0] PE_inst,
  output logic                 init,
  output logic                 run,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  ldr_state_t        r_state;
  ldr_state_t        w_state_next;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_inst_num;
  logic [CNT_W-1:0]  r_run_cycles;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_run_cnt;
  logic              w_init;
  logic              w_flush;

  // An abort only matters while an operation is in progress.
  assign w_flush = abort && (r_state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the operation parameters on an accepted start, clamped to the buffer depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base       <= '0;
      r_inst_num   <= '0;
      r_run_cycles <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_base       <= base_addr;
      r_inst_num   <= (inst_num   > DEPTH_C) ? DEPTH_C : inst_num;
      r_run_cycles <= (run_cycles > DEPTH_C) ? DEPTH_C : run_cycles;
    end
  end

  // Read, write (init) and run counters; all restart in the clear cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_run_cnt <= '0;
    end else if (r_state == CLR) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_run_cnt <= '0;
    end else begin
      if (r_state == FETCH) begin
        r_rd_cnt <= r_rd_cnt + ONE_C;
      end
      if (r_state == RUN) begin
        r_run_cnt <= r_run_cnt + ONE_C;
      end
      if (w_init) begin
        r_wr_cnt <= r_wr_cnt + ONE_C;
      end
    end
  end

  // Next-state and Moore strobes; abort overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    pe_rst       = 1'b0;
    run          = 1'b0;
    done         = 1'b0;
    busy         = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = CLR;
        end
      end
      CLR: begin
        pe_rst = 1'b1;
        if (r_inst_num != '0) begin
          w_state_next = FETCH;
        end else if (r_run_cycles != '0) begin
          w_state_next = RUN;
        end else begin
          w_state_next = DONE;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = r_base + ADDR_W'(r_rd_cnt);
        if (r_rd_cnt == (r_inst_num - ONE_C)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the cycle that carries the final init so run follows it directly.
        if (w_init && (r_wr_cnt == (r_inst_num - ONE_C))) begin
          w_state_next = (r_run_cycles != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        run = 1'b1;
        if (r_run_cnt == (r_run_cycles - ONE_C)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_flush) begin
      w_state_next = IDLE;
    end
  end

  cfg_fetch_pipe #(
    .W (PE_INST_W)
  ) u_fetch_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_flush),
    .i_rd_en   (mem_rd_en),
    .i_rdata   (mem_rdata),
    .o_pe_inst (PE_inst),
    .o_init    (w_init)
  );

  assign init = w_init;

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed bench for pe_config_loader with a registered-read config memory
// and a small PE model that captures every init into its config buffer.
`timescale 1ns/1ps
module tb_pe_config_loader;

  localparam int W  = 48;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [5:0]    inst_num;
  logic [5:0]    run_cycles;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic          pe_rst;
  logic [W-1:0]  PE_inst;
  logic          init;
  logic          run;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_config_loader #(
    .PE_INST_W (W),
    .ADDR_W    (AW),
    .DEPTH     (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .inst_num   (inst_num),
    .run_cycles (run_cycles),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .pe_rst     (pe_rst),
    .PE_inst    (PE_inst),
    .init       (init),
    .run        (run),
    .busy       (busy),
    .done       (done)
  );

  // Content stored at each config-memory address.
  function automatic logic [W-1:0] word_of(input logic [AW-1:0] a);
    return {8'hAB, 30'd0, a};
  endfunction

  // Config memory: data returns one cycle after the read strobe.
  logic [W-1:0] cfg_mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) cfg_mem[i] = word_of(AW'(i));
  end
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= cfg_mem[mem_addr];
  end

  // PE model: cleared by pe_rst, appends PE_inst to its buffer on each init.
  logic [W-1:0] PE_inst_r = '0;
  logic [W-1:0] pe_buf [0:31];
  int           pe_cnt = 0;
  always @(posedge clk) begin
    if (rst || pe_rst) begin
      pe_cnt <= 0;
    end else if (init) begin
      PE_inst_r           <= PE_inst;
      pe_buf[pe_cnt[4:0]] <= PE_inst;
      pe_cnt              <= pe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kill: 0 = run to completion, 1 = abort on the 2nd init, 2 = rst on the 2nd run cycle.
  // Local cycle 0 is the first cycle after the start edge (the clear cycle).
  task automatic do_op(input string name, input logic [AW-1:0] b, input logic [5:0] n,
                       input logic [5:0] r, input int kill, input bit start_in_done);
    int nc, rc, n_prst, n_rd, n_init, n_run, n_done, n_both, n_hold;
    int c_prst, c_rd0, c_init0, c_initl, c_run0, c_runl, c_done, c_first_run;
    bit killed, finished;
    logic [W-1:0]  last_word;
    logic [AW-1:0] ea;
    nc = (n > 6'd32) ? 32 : int'(n);
    rc = (r > 6'd32) ? 32 : int'(r);
    n_prst = 0; n_rd = 0; n_init = 0; n_run = 0; n_done = 0; n_both = 0; n_hold = 0;
    c_prst = -1; c_rd0 = -1; c_init0 = -1; c_initl = -1; c_run0 = -1; c_runl = -1; c_done = -1;
    killed = 1'b0; finished = 1'b0; last_word = '0;

    @(negedge clk);
    base_addr = b; inst_num = n; run_cycles = r; start = 1'b1;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      if (killed) begin
        check({name, ":kill_strobes"}, {58'd0, mem_rd_en, pe_rst, init, run, done, busy}, 64'd0);
        if (kill == 2) begin
          check({name, ":rst_pe_inst"}, PE_inst, 64'd0);
          check({name, ":rst_mem_addr"}, mem_addr, 64'd0);
        end
        finished = 1'b1;
      end else if (!busy) begin
        finished = 1'b1;
      end else begin
        if (pe_rst) begin n_prst++; c_prst = c; end
        if (mem_rd_en) begin
          ea = b + AW'(n_rd);
          check({name, ":mem_addr"}, mem_addr, ea);
          if (n_rd == 0) c_rd0 = c;
          n_rd++;
        end
        if (init) begin
          ea = b + AW'(n_init);
          check({name, ":pe_inst"}, PE_inst, word_of(ea));
          if (n_init == 0) c_init0 = c;
          c_initl   = c;
          last_word = PE_inst;
          n_init++;
        end else if (n_init > 0 && PE_inst !== last_word) begin
          n_hold++;
        end
        if (run) begin
          if (n_run == 0) c_run0 = c;
          c_runl = c;
          n_run++;
        end
        if (done) begin n_done++; c_done = c; end
        if (init && run) n_both++;
        // A start while busy must not be taken.
        if (c == 1) begin
          start = 1'b1; base_addr = 10'h2AA; inst_num = 6'd1; run_cycles = 6'd1;
        end
        if (done && start_in_done) start = 1'b1;
        if (kill == 1 && init && n_init == 2) begin abort = 1'b1; killed = 1'b1; end
        if (kill == 2 && run && n_run == 2)   begin rst = 1'b1;   killed = 1'b1; end
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    if (!finished) check({name, ":timeout"}, 64'd0, 64'd1);

    check({name, ":init_and_run"}, 64'(n_both), 64'd0);
    check({name, ":pe_inst_hold"}, 64'(n_hold), 64'd0);
    if (kill != 0) begin
      check({name, ":no_done"}, 64'(n_done), 64'd0);
    end else begin
      c_first_run = (nc > 0) ? nc + 3 : 1;
      check({name, ":pe_rst_cnt"}, 64'(n_prst), 64'd1);
      check({name, ":pe_rst_cyc"}, 64'(c_prst), 64'd0);
      check({name, ":rd_cnt"}, 64'(n_rd), 64'(nc));
      check({name, ":init_cnt"}, 64'(n_init), 64'(nc));
      check({name, ":run_cnt"}, 64'(n_run), 64'(rc));
      check({name, ":done_cnt"}, 64'(n_done), 64'd1);
      check({name, ":done_cyc"}, 64'(c_done), 64'(c_first_run + rc));
      if (nc > 0) begin
        check({name, ":rd_first_cyc"}, 64'(c_rd0), 64'd1);
        check({name, ":init_first_cyc"}, 64'(c_init0), 64'd3);
        check({name, ":init_last_cyc"}, 64'(c_initl), 64'(nc + 2));
      end
      if (rc > 0) begin
        check({name, ":run_first_cyc"}, 64'(c_run0), 64'(c_first_run));
        check({name, ":run_last_cyc"}, 64'(c_runl), 64'(c_first_run + rc - 1));
      end
    end
    $display("op %-12s base=0x%03h n=%0d r=%0d kill=%0d : pe_rst=%0d rd=%0d init=%0d run=%0d done=%0d",
             name, b, n, r, kill, n_prst, n_rd, n_init, n_run, n_done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; inst_num = '0; run_cycles = '0;
    repeat (3) @(negedge clk);
    check("reset:strobes", {58'd0, mem_rd_en, pe_rst, init, run, done, busy}, 64'd0);
    check("reset:pe_inst", PE_inst, 64'd0);
    check("reset:mem_addr", mem_addr, 64'd0);
    rst = 1'b0;

    do_op("basic",       10'h010, 6'd3,  6'd3,  0, 1'b1);
    do_op("no_inst",     10'h055, 6'd0,  6'd5,  0, 1'b0);
    do_op("clamp",       10'h100, 6'd40, 6'd40, 0, 1'b0);
    do_op("wrap",        10'h3FE, 6'd4,  6'd2,  0, 1'b0);
    do_op("abort",       10'h020, 6'd5,  6'd3,  1, 1'b0);
    do_op("after_abort", 10'h030, 6'd2,  6'd2,  0, 1'b0);
    do_op("rst_in_run",  10'h040, 6'd2,  6'd4,  2, 1'b0);
    do_op("pe_load",     10'h000, 6'd4,  6'd4,  0, 1'b0);

    // PE model contents after loading addresses 0..3.
    check("pe:count", 64'(pe_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pe:buf%0d", i), pe_buf[i], word_of(AW'(i)));
    end
    check("pe:inst_r", PE_inst_r, word_of(10'd3));

    do_op("empty",       10'h000, 6'd0,  6'd0,  0, 1'b0);
    do_op("no_run",      10'h200, 6'd2,  6'd0,  0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_config_loader.md
PE_CONFIG_LOADER -- requirements
Module: pe_config_loader

Interface
REQ-001 The block SHALL have parameter PE_INST_W, default `PE_inst (48), meaning the PE instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the config-memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 32, meaning the PE config-buffer depth.
REQ-004 Port clk  input  1  is the single clock; all logic is on the rising edge.
REQ-005 Port rst  input  1  is the reset: synchronous, active-high.
REQ-006 Port start  input  1  is a one-cycle load-and-run request.
REQ-007 Port abort  input  1  terminates the current operation.
REQ-008 Port base_addr  input  ADDR_W  is the first config-memory word, sampled at start.
REQ-009 Port inst_num  input  6  is the instruction count, sampled at start.
REQ-010 Port run_cycles  input  6  is the run length, sampled at start.
REQ-011 Port mem_rd_en  output  1  is the config-memory read strobe.
REQ-012 Port mem_addr  output  ADDR_W  is the config-memory read address.
REQ-013 Port mem_rdata  input  PE_INST_W  is read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 Port pe_rst  output  1  is the PE counter/buffer clear.
REQ-015 Port PE_inst  output  PE_INST_W  is the instruction word to the PE.
REQ-016 Port init  output  1  is the PE config-buffer write strobe.
REQ-017 Port run  output  1  is the PE run strobe.
REQ-018 Port busy  output  1  is high in every state except IDLE.
REQ-019 Port done  output  1  is a one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have states IDLE, CLR, FETCH, DRAIN, RUN, DONE.
REQ-021 In IDLE, start SHALL latch base_addr/inst_num/run_cycles and enter CLR next cycle; start is ignored outside IDLE.
REQ-022 inst_num or run_cycles above DEPTH SHALL be clamped to DEPTH at latch.
REQ-023 CLR SHALL last exactly 1 cycle with pe_rst=1, then go to FETCH, or to RUN if inst_num=0, or to DONE if both are 0.
REQ-024 FETCH SHALL assert mem_rd_en for inst_num consecutive cycles, with mem_addr=base_addr+k on the k-th cycle (k=0..inst_num-1), wrapping modulo 2^ADDR_W.
REQ-025 A read issued at cycle t SHALL produce registered PE_inst=mem_rdata and init=1 at cycle t+2.
REQ-026 init pulses SHALL be back-to-back, exactly inst_num of them.
REQ-027 DRAIN SHALL hold until the last init has been issued.
REQ-028 run SHALL assert for exactly run_cycles consecutive cycles, starting the cycle after the last init (or the cycle after CLR if inst_num=0).
REQ-029 run_cycles=0 SHALL skip RUN.
REQ-030 init and run SHALL never be high in the same cycle.
REQ-031 DONE SHALL last 1 cycle with done=1, then return to IDLE; a start in the DONE cycle is ignored.
REQ-032 abort in any non-IDLE state SHALL force IDLE next cycle, with all strobes low from that cycle and no done; abort wins over every other event in the same cycle.
REQ-033 PE_inst SHALL hold its last value when init=0.

Reset
REQ-034 When rst=1, the block SHALL go to IDLE and drive mem_rd_en, pe_rst, init, run, busy, done and PE_inst to 0 and mem_addr to 0 from the next edge.
REQ-035 rst asserted mid-operation SHALL discard the operation and produce no done.
REQ-036 rst SHALL have priority over abort and start.

Structure
REQ-037 The state encoding and the DEPTH constant SHALL live in the shared param_define package alongside `PE_inst.
REQ-038 The block SHALL contain one sub-module, cfg_fetch_pipe: a 2-stage rdata/valid register producing PE_inst/init.
REQ-039 The FSM and the rd/wr/run counters SHALL be in the top module.

Verification
REQ-040 start with base_addr=0x10, inst_num=3, run_cycles=3 -> pe_rst 1 cycle; mem_addr 0x10,0x11,0x12; init×3 carrying those words; run×3 immediately after; done 1 cycle later.
REQ-041 inst_num=0, run_cycles=5 -> pe_rst, then run×5, then done; no mem_rd_en and no init.
REQ-042 inst_num=40, run_cycles=40 -> clamped: exactly 32 inits, then 32 runs.
REQ-043 base_addr=0x3FE, inst_num=4 -> mem_addr 0x3FE,0x3FF,0x000,0x001.
REQ-044 abort during the 2nd init, and separately rst during RUN -> all strobes 0 next cycle, busy=0, no done; a fresh start afterwards completes normally.
REQ-045 Loader connected to the PE model, 4 instructions, run_cycles=4 -> the PE's PE_inst_r sequence equals mem words 0..3.
